// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for a shared N_SRC:1 byte mux: select, settle, capture, valid/ready hand-off.
// Optional MUX_SCHED_PRIO0_EN gives source 0 absolute priority over the round-robin group.
module mux_rr_sched #(
  parameter int N_SRC = 12,
  parameter int DW    = 8,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic [DW-1:0]    mux_y,
  output logic [SELW-1:0]  sel,
  output logic [N_SRC-1:0] grant,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t            state, state_n;
  logic [SELW-1:0]   sel_n, last, last_n, winner;
  logic [N_SRC-1:0]  grant_n, req_rr;
  logic [DW-1:0]     data_n;
  logic              valid_n, found;

  // Circular search starting just after the last served source.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
`ifdef MUX_SCHED_PRIO0_EN
    req_rr = {req[N_SRC-1:1], 1'b0};
`else
    req_rr = req;
`endif
    for (int i = 0; i < N_SRC; i++) begin
      idx = (int'(last) + 1 + i) % N_SRC;
      if (!found && req_rr[idx]) begin
        found  = 1'b1;
        winner = SELW'(idx);
      end
    end
`ifdef MUX_SCHED_PRIO0_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    grant_n = '0;
    data_n  = out_data;
    valid_n = out_valid;
    last_n  = last;
    case (state)
      IDLE: if (found) begin
        sel_n   = winner;
        state_n = SETTLE;
      end
      SETTLE: state_n = CAPTURE;
      CAPTURE: begin
        data_n  = mux_y;
        valid_n = 1'b1;
        grant_n = {{(N_SRC-1){1'b0}}, 1'b1} << sel;
`ifdef MUX_SCHED_PRIO0_EN
        if (sel != '0) last_n = sel;
`else
        last_n  = sel;
`endif
        state_n = HOLD;
      end
      HOLD: if (out_ready) begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      grant     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      last      <= SELW'(N_SRC - 1);
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      last      <= last_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched; the mux is modelled as {4'hA, sel}.
module tb_mux_rr_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] req;
  logic [7:0]  mux_y;
  logic [3:0]  sel;
  logic [11:0] grant;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, busy;
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;
  assign mux_y = {4'hA, sel};

  mux_rr_sched #(.N_SRC(12), .DW(8), .SELW(4)) dut (
    .clk(clk), .reset(reset), .req(req), .mux_y(mux_y), .sel(sel),
    .grant(grant), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; out_ready = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; out_ready = 1'b0;
    step(2);
    vectors++;
    if ({sel, grant, out_valid, busy} !== 18'h0) begin
      errors++; $display("FAIL reset_hold sel=%0d grant=%h valid=%b busy=%b need 0", sel, grant, out_valid, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      vectors++;
      if (sel !== 4'd0 || out_valid !== 1'b0 || grant !== 12'h0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc=%0d sel=%0d valid=%b grant=%h busy=%b need 0", i, sel, out_valid, grant, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 12'h020; out_ready = 1'b1;
    step(1);
    vectors++;
    if (sel !== 4'd5 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_sel sel=%0d busy=%b valid=%b need 5/1/0", sel, busy, out_valid);
    end
    req = '0;
    step(1);
    vectors++;
    if (out_valid !== 1'b0 || grant !== 12'h0) begin
      errors++; $display("FAIL single_settle valid=%b grant=%h need 0", out_valid, grant);
    end
    step(1);
    vectors++;
    if (out_valid !== 1'b1 || grant !== 12'h020 || out_data !== 8'hA5) begin
      errors++; $display("FAIL single_capture valid=%b grant=%h data=%h need 1/020/a5", out_valid, grant, out_data);
    end
    step(1);
    vectors++;
    if (out_valid !== 1'b0 || grant !== 12'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done valid=%b grant=%h busy=%b need 0", out_valid, grant, busy);
    end
  endtask

  task automatic test_all_req();
    do_reset();
    req = 12'hFFF; out_ready = 1'b1;
    for (int s = 0; s < 13; s++) begin
      for (int c = 0; c < 3; c++) begin
        step(1);
        vectors++;
        if ($countones(grant) > 1 || (c < 2 && grant !== 12'h0)) begin
          errors++; $display("FAIL rr_grant_early slot=%0d cyc=%0d grant=%h need 0", s, c, grant);
        end
      end
      vectors++;
      if (sel !== 4'(s % 12) || grant !== (12'h1 << (s % 12)) || out_data !== {4'hA, 4'(s % 12)}) begin
        errors++; $display("FAIL rr_order slot=%0d sel=%0d grant=%h data=%h need sel=%0d", s, sel, grant, out_data, s % 12);
      end
      step(1);
      vectors++;
      if (grant !== 12'h0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL rr_pulse slot=%0d grant=%h valid=%b need 0", s, grant, out_valid);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 12'h801; out_ready = 1'b0;
    step(3);
    vectors++;
    if (out_valid !== 1'b1 || grant !== 12'h001 || out_data !== 8'hA0) begin
      errors++; $display("FAIL bp_first valid=%b grant=%h data=%h need 1/001/a0", out_valid, grant, out_data);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0 || busy !== 1'b1 || grant !== 12'h0 || sel !== 4'd0) begin
        errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h busy=%b grant=%h sel=%0d", i, out_valid, out_data, busy, grant, sel);
      end
    end
    out_ready = 1'b1;
    step(1);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_xfer valid=%b busy=%b need 0/0", out_valid, busy);
    end
    step(3);
    vectors++;
    if (sel !== 4'd11 || grant !== 12'h800 || out_data !== 8'hAB) begin
      errors++; $display("FAIL bp_next sel=%0d grant=%h data=%h need 11/800/ab", sel, grant, out_data);
    end
    req = '0;
    step(1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 12'h002; out_ready = 1'b1;
    step(1);
    vectors++;
    if (sel !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_settle sel=%0d busy=%b need 1/1", sel, busy);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (sel !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || grant !== 12'h0 || out_data !== 8'h0) begin
      errors++; $display("FAIL mid_async sel=%0d busy=%b valid=%b grant=%h data=%h need 0", sel, busy, out_valid, grant, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      vectors++;
      if (grant !== 12'h0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_nogrant cyc=%0d grant=%h valid=%b need 0", i, grant, out_valid);
      end
    end
    reset = 1'b0; req = 12'h004;
    step(3);
    vectors++;
    if (sel !== 4'd2 || grant !== 12'h004 || out_data !== 8'hA2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_after sel=%0d grant=%h data=%h valid=%b need 2/004/a2/1", sel, grant, out_data, out_valid);
    end
    req = '0;
    step(1);
  endtask

  task automatic test_two_src();
    logic [11:0] exp [4];
`ifdef MUX_SCHED_PRIO0_EN
    exp = '{12'h001, 12'h001, 12'h001, 12'h002};
`else
    exp = '{12'h001, 12'h002, 12'h001, 12'h002};
`endif
    do_reset();
    req = 12'h003; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step(3);
      vectors++;
      if (grant !== exp[s]) begin
        errors++; $display("FAIL two_src slot=%0d grant=%h need %h", s, grant, exp[s]);
      end
      if (s == 2) req = 12'h002;
      step(1);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_backpressure();
    test_reset_mid();
    test_two_src();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
